// File: rtl/jtcontra_nmix_pkg.sv
// Shared constants and width helpers for the N-layer colour mixer.
// Optional CPU palette readback is enabled with JTCONTRA_NMIX_RDBACK_EN.
package jtcontra_nmix_pkg;

  // Colour field offsets inside a 16-bit palette entry
  localparam int R_LSB = 0;
  localparam int G_LSB = 5;
  localparam int B_LSB = 10;

  localparam logic [3:0] TRANSP_CODE = 4'h0;

  // Slot k holds layer k; the top uses only the low 2*LAYERS bits
  localparam logic [7:0] PRIO_IDENTITY = 8'b11_10_01_00;

  function automatic int calc_lw(input int layers);
    return (layers == 2) ? 1 : 2;
  endfunction

  function automatic int calc_aw(input int layers, input int pxlw);
    return calc_lw(layers) + pxlw + 1;
  endfunction

endpackage

// File: rtl/jtcontra_nmix_if.sv
// CPU-side bus of the colour mixer: palette and priority register access.
// pal_dout carries readback data only when JTCONTRA_NMIX_RDBACK_EN is defined.
interface jtcontra_nmix_if #(
  parameter int AW = 9
);
  logic          cpu_cen;
  logic          pal_cs;
  logic          prio_cs;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic [7:0]    pal_dout;

  modport master (
    output cpu_cen, pal_cs, prio_cs, cpu_rnw, cpu_addr, cpu_dout,
    input  pal_dout
  );

  modport slave (
    input  cpu_cen, pal_cs, prio_cs, cpu_rnw, cpu_addr, cpu_dout,
    output pal_dout
  );
endinterface

// File: rtl/jtcontra_nmix_pal.sv
// True dual-port palette RAM: byte-wide CPU port, 16-bit registered video read.
// The CPU read path exists only when JTCONTRA_NMIX_RDBACK_EN is defined.
module jtcontra_nmix_pal #(
  parameter int IW = 8
) (
  input  logic          clk,
`ifdef JTCONTRA_NMIX_RDBACK_EN
  input  logic          rstn,
  input  logic          cpu_re,
  output logic [7:0]    cpu_q,
`endif
  input  logic          cpu_we,
  input  logic [IW:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          vid_cen,
  input  logic [IW-1:0] vid_addr,
  output logic [15:0]   vid_q
);

`ifdef JTCONTRA_NMIX_RDBACK_EN
  logic [15:0] cpu_rd;
  logic        sel_reg;
`endif

  // One RAM per byte lane so each lane infers a plain 8-bit wide block RAM
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem [2**IW];
      logic [7:0] vid_reg;

      // Read-before-write: a same-clk CPU write leaves the old word on video
      always_ff @(posedge clk) begin
        if (cpu_we && cpu_addr[0] == 1'(gi))
          mem[cpu_addr[IW:1]] <= cpu_din;
        if (vid_cen)
          vid_reg <= mem[vid_addr];
      end
      assign vid_q[gi*8 +: 8] = vid_reg;

`ifdef JTCONTRA_NMIX_RDBACK_EN
      logic [7:0] rd_reg;
      always_ff @(posedge clk) begin
        if (!rstn)       rd_reg <= '0;
        else if (cpu_re) rd_reg <= mem[cpu_addr[IW:1]];
      end
      assign cpu_rd[gi*8 +: 8] = rd_reg;
`endif
    end
  endgenerate

`ifdef JTCONTRA_NMIX_RDBACK_EN
  always_ff @(posedge clk) begin
    if (!rstn)       sel_reg <= 1'b0;
    else if (cpu_re) sel_reg <= cpu_addr[0];
  end
  assign cpu_q = sel_reg ? cpu_rd[15:8] : cpu_rd[7:0];
`endif

endmodule

// File: rtl/jtcontra_nmix.sv
// N-layer colour mixer: runtime priority scan, 15-bit palette, delayed blanking.
// Define JTCONTRA_NMIX_RDBACK_EN to enable CPU palette readback on pal_dout.
module jtcontra_nmix
  import jtcontra_nmix_pkg::*;
#(
  parameter int LAYERS = 2,
  parameter int PXLW   = 7
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   pxl_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly,
  input  logic [LAYERS*PXLW-1:0] pxl_in,
  input  logic [LAYERS-1:0]      gfx_en,
  jtcontra_nmix_if.slave         cpu,
  output logic [4:0]             red,
  output logic [4:0]             green,
  output logic [4:0]             blue
);

  localparam int LW = calc_lw(LAYERS);
  localparam int IW = LW + PXLW;
  localparam int PW = 2 * LAYERS;

  logic [PW-1:0]   prio_reg;
  logic [PXLW-1:0] pxl_lyr [LAYERS];
  logic [LAYERS-1:0] opq_in;
  logic [PXLW-1:0] pxl_s1 [LAYERS];
  logic [LAYERS-1:0] opq_s1;
  logic            hb_s1, vb_s1, hb_s2, vb_s2;
  logic [3:0]      opq_pad;
  logic [LW-1:0]   win;
  logic            found;
  logic [1:0]      slot;
  logic [IW-1:0]   idx_s2;
  logic [15:0]     vid_q;
  logic            pal_we;

  always_ff @(posedge clk) begin
    if (!rstn)
      prio_reg <= PRIO_IDENTITY[PW-1:0];
    else if (cpu.prio_cs && !cpu.cpu_rnw && cpu.cpu_cen)
      prio_reg <= cpu.cpu_dout[PW-1:0];
  end

  generate
    for (genvar gi = 0; gi < LAYERS; gi++) begin : g_unpack
      assign pxl_lyr[gi] = pxl_in[gi*PXLW +: PXLW];
      assign opq_in[gi]  = gfx_en[gi] && (pxl_lyr[gi][3:0] != TRANSP_CODE);
    end
  endgenerate

  // S1: capture pixels, masked opacity and blanking
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < LAYERS; k++) pxl_s1[k] <= '0;
      opq_s1 <= '0;
      hb_s1  <= 1'b0;
      vb_s1  <= 1'b0;
    end else if (pxl_cen) begin
      pxl_s1 <= pxl_lyr;
      opq_s1 <= opq_in;
      hb_s1  <= LHBL;
      vb_s1  <= LVBL;
    end
  end

  assign opq_pad = 4'(opq_s1);

  // Fallback is the last slot's layer, clamped when it names a missing layer
  always_comb begin
    found = 1'b0;
    slot  = prio_reg[PW-1 -: 2];
    win   = (int'(slot) < LAYERS) ? LW'(slot) : LW'(LAYERS - 1);
    for (int i = 0; i < LAYERS; i++) begin
      slot = prio_reg[2*i +: 2];
      if (!found && int'(slot) < LAYERS && opq_pad[slot]) begin
        win   = LW'(slot);
        found = 1'b1;
      end
    end
  end

  // S2: winner and palette index
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_s2 <= '0;
      hb_s2  <= 1'b0;
      vb_s2  <= 1'b0;
    end else if (pxl_cen) begin
      idx_s2 <= {win, pxl_s1[win]};
      hb_s2  <= hb_s1;
      vb_s2  <= vb_s1;
    end
  end

  assign pal_we = cpu.pal_cs && !cpu.cpu_rnw && cpu.cpu_cen;

  jtcontra_nmix_pal #(.IW(IW)) u_pal (
    .clk      (clk),
`ifdef JTCONTRA_NMIX_RDBACK_EN
    .rstn     (rstn),
    .cpu_re   (cpu.pal_cs && cpu.cpu_rnw),
    .cpu_q    (cpu.pal_dout),
`endif
    .cpu_we   (pal_we),
    .cpu_addr (cpu.cpu_addr),
    .cpu_din  (cpu.cpu_dout),
    .vid_cen  (pxl_cen),
    .vid_addr (idx_s2),
    .vid_q    (vid_q)
  );

`ifndef JTCONTRA_NMIX_RDBACK_EN
  assign cpu.pal_dout = 8'h00;
`endif

  // S3: the palette word lands in the RAM output register alongside blanking
  always_ff @(posedge clk) begin
    if (!rstn) begin
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else if (pxl_cen) begin
      LHBL_dly <= hb_s2;
      LVBL_dly <= vb_s2;
    end
  end

  assign red   = (LHBL_dly && LVBL_dly) ? vid_q[R_LSB +: 5] : 5'd0;
  assign green = (LHBL_dly && LVBL_dly) ? vid_q[G_LSB +: 5] : 5'd0;
  assign blue  = (LHBL_dly && LVBL_dly) ? vid_q[B_LSB +: 5] : 5'd0;

endmodule

// File: tb/tb_jtcontra_nmix.sv
// Randomised self-checking bench for jtcontra_nmix (LAYERS=2, PXLW=7).
// Honours JTCONTRA_NMIX_RDBACK_EN when predicting pal_dout.
module tb_jtcontra_nmix;
  localparam int LAYERS = 2;
  localparam int PXLW   = 7;
  localparam int AW     = 9;
  localparam int NENT   = 256;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        LHBL = 1'b0, LVBL = 1'b0;
  logic        LHBL_dly, LVBL_dly;
  logic [13:0] pxl_in = '0;
  logic [1:0]  gfx_en = 2'b11;
  logic [4:0]  red, green, blue;

  jtcontra_nmix_if #(.AW(AW)) cpu_bus ();

  jtcontra_nmix #(.LAYERS(LAYERS), .PXLW(PXLW)) dut (
    .clk(clk), .rstn(rstn), .pxl_cen(pxl_cen),
    .LHBL(LHBL), .LVBL(LVBL), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
    .pxl_in(pxl_in), .gfx_en(gfx_en), .cpu(cpu_bus),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] r, g, b;
    logic h, v;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] pal_m [NENT];
  logic [3:0]  prio_m;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the priority slots as the mixing rules describe
  function automatic exp_t model(input logic [6:0] p0, input logic [6:0] p1,
                                 input logic [1:0] en, input logic h, input logic v);
    logic [6:0]  pix [2];
    int          win, s;
    logic [15:0] c;
    exp_t        e;
    pix[0] = p0;
    pix[1] = p1;
    win = -1;
    for (int k = 0; k < 2; k++) begin
      s = int'((prio_m >> (2*k)) & 4'd3);
      if (win < 0 && s < 2 && en[s] && pix[s][3:0] != 4'h0) win = s;
    end
    if (win < 0) begin
      s = int'((prio_m >> 2) & 4'd3);
      win = (s < 2) ? s : 1;
    end
    c = pal_m[win*128 + int'(pix[win])];
    e.h = h;
    e.v = v;
    if (h && v) {e.b, e.g, e.r} = c[14:0];
    else {e.b, e.g, e.r} = 15'd0;
    return e;
  endfunction

  task automatic step(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [1:0] en, input logic h, input logic v);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    pxl_in = {p1, p0};
    gfx_en = en;
    LHBL   = h;
    LVBL   = v;
    exp_q.push_back(model(p0, p1, en, h, v));
    pxl_cen = 1'b1;
    @(posedge clk);
    #1 pxl_cen = 1'b0;
    e = exp_q.pop_front();
    check("rgb", {red, green, blue}, {e.r, e.g, e.b});
    check("blank_dly", {LHBL_dly, LVBL_dly}, {e.h, e.v});
  endtask

  // Two blanked pixels push every visible pixel out before CPU changes
  task automatic drain();
    step(7'd0, 7'd0, 2'b11, 1'b0, 1'b0);
    step(7'd0, 7'd0, 2'b11, 1'b0, 1'b0);
  endtask

  task automatic cpu_wr(input logic [8:0] addr, input logic [7:0] data, input logic cen);
    @(negedge clk);
    cpu_bus.pal_cs = 1'b1; cpu_bus.cpu_rnw = 1'b0; cpu_bus.cpu_cen = cen;
    cpu_bus.cpu_addr = addr; cpu_bus.cpu_dout = data;
    @(posedge clk);
    #1 cpu_bus.pal_cs = 1'b0; cpu_bus.cpu_cen = 1'b0;
    if (cen) begin
      if (addr[0]) pal_m[addr[8:1]][15:8] = data;
      else         pal_m[addr[8:1]][7:0]  = data;
    end
  endtask

  task automatic prio_wr(input logic [7:0] data);
    @(negedge clk);
    cpu_bus.prio_cs = 1'b1; cpu_bus.cpu_rnw = 1'b0; cpu_bus.cpu_cen = 1'b1;
    cpu_bus.cpu_dout = data;
    @(posedge clk);
    #1 cpu_bus.prio_cs = 1'b0; cpu_bus.cpu_cen = 1'b0;
    prio_m = data[3:0];
  endtask

  task automatic cpu_rd(input logic [8:0] addr);
    logic [7:0] want;
    logic [15:0] w;
    w = pal_m[addr[8:1]];
`ifdef JTCONTRA_NMIX_RDBACK_EN
    want = addr[0] ? w[15:8] : w[7:0];
`else
    want = 8'h00;
`endif
    @(negedge clk);
    cpu_bus.pal_cs = 1'b1; cpu_bus.cpu_rnw = 1'b1; cpu_bus.cpu_addr = addr;
    @(posedge clk);
    #1 cpu_bus.pal_cs = 1'b0;
    check("pal_dout", 32'(cpu_bus.pal_dout), 32'(want));
    cpu_bus.cpu_addr = addr ^ 9'h055;
    @(posedge clk);
    #1 check("pal_dout_hold", 32'(cpu_bus.pal_dout), 32'(want));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rgb", {red, green, blue}, 32'd0);
    check("rst_blank", {LHBL_dly, LVBL_dly}, 32'd0);
    check("rst_pal_dout", 32'(cpu_bus.pal_dout), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    prio_m = 4'b0100;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic rand_pixels(input int n);
    logic [6:0] p0, p1;
    for (int i = 0; i < n; i++) begin
      p0 = 7'($urandom_range(0, 127));
      p1 = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 2) == 0) p0[3:0] = 4'h0;
      if ($urandom_range(0, 2) == 0) p1[3:0] = 4'h0;
      step(p0, p1, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) != 0, $urandom_range(0, 15) != 0);
    end
  endtask

  initial begin
    cpu_bus.cpu_cen = 1'b0; cpu_bus.pal_cs = 1'b0; cpu_bus.prio_cs = 1'b0;
    cpu_bus.cpu_rnw = 1'b1; cpu_bus.cpu_addr = '0; cpu_bus.cpu_dout = '0;
    prio_m = 4'b0100;
    repeat (2) @(posedge clk);
    reset_dut();

    for (int a = 0; a < 2*NENT; a++) cpu_wr(9'(a), 8'($urandom_range(0, 255)), 1'b1);

    // Layer 0 colour 0x05 -> magenta
    cpu_wr(9'h00A, 8'h1F, 1'b1);
    cpu_wr(9'h00B, 8'h7C, 1'b1);
    step(7'h05, 7'h00, 2'b11, 1'b1, 1'b1);
    // Background from layer 1 code 0x10 -> pure green
    cpu_wr(9'h120, 8'hE0, 1'b1);
    cpu_wr(9'h121, 8'h03, 1'b1);
    step(7'h00, 7'h10, 2'b11, 1'b1, 1'b1);
    step(7'h13, 7'h27, 2'b11, 1'b1, 1'b1);
    step(7'h13, 7'h27, 2'b10, 1'b1, 1'b1);
    step(7'h13, 7'h27, 2'b11, 1'b0, 1'b1);
    drain();
    prio_wr(8'b0000_0001);
    step(7'h13, 7'h27, 2'b11, 1'b1, 1'b1);
    step(7'h13, 7'h20, 2'b11, 1'b1, 1'b1);
    drain();

    for (int ph = 0; ph < 8; ph++) begin
      prio_wr(8'($urandom_range(0, 255)));
      for (int w = 0; w < 4; w++)
        cpu_wr(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)),
               $urandom_range(0, 3) != 0);
      rand_pixels(24);
      drain();
    end

    cpu_wr(9'h013, 8'hA5, 1'b1);
    cpu_rd(9'h013);
    for (int r = 0; r < 6; r++) cpu_rd(9'($urandom_range(0, 511)));

    // Mid-frame reset also restores the identity priority order
    prio_wr(8'b0000_0111);
    rand_pixels(5);
    reset_dut();
    rand_pixels(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtcontra_nmix.md
# jtcontra_nmix

Parametrised N-layer colour mixer for the Konami 007121-based video path. It takes LAYERS tile/object pixel streams and selects one pixel per position using a CPU-programmable priority order. It then looks the pixel up in a CPU-writable 15-bit palette and drives blanked RGB with matching delayed blanking. It sits between the gfx layer instances and the video output, replacing the fixed two-layer mixer for boards with more layers or runtime priority.

## Interface
- LAYERS, 2, number of pixel layers (2..4)
- PXLW, 7, bits per layer pixel; low 4 bits are the colour code, and code 0 is transparent
- LW (derived), 1 if LAYERS==2 else 2, layer-index width
- AW (derived), LW+PXLW+1, CPU palette byte-address width

Ports:
- clk  in  1  system clock (48 MHz)
- rstn  in  1  synchronous active-low reset
- pxl_cen  in  1  pixel clock enable; the pipeline advances only on it
- cpu_cen  in  1  CPU bus strobe qualifier
- LHBL, LVBL  in  1 each  active-low blanking, aligned with the pixel inputs
- LHBL_dly, LVBL_dly  out  1 each  blanking aligned with the RGB outputs
- pxl_in  in  LAYERS*PXLW  packed layer pixels; layer k occupies bits [k*PXLW +: PXLW]
- gfx_en  in  LAYERS  test mask; 0 forces that layer transparent
- pal_cs  in  1  palette select
- prio_cs  in  1  priority register select
- cpu_rnw  in  1  1=read, 0=write
- cpu_addr  in  AW  palette byte address
- cpu_dout  in  8  CPU write data
- pal_dout  out  8  palette read data
- red, green, blue  out  5 each  colour output

## Operation
- Palette: 2^(LW+PXLW) entries × 16 bits, byte addressed.
  - Entry index = {layer, pixel}.
  - Even byte = {G[2:0], R[4:0]}; odd byte = {x, B[4:0], G[4:3]}.
- Palette write: on a clk where pal_cs & ~cpu_rnw & cpu_cen, write byte cpu_addr[0] of entry cpu_addr[AW-1:1].
- Palette read: pal_dout is registered and holds the selected byte one clk after pal_cs & cpu_rnw. Otherwise it holds its last value.
- Priority register: LAYERS slots of 2 bits each; slot 0 is the top.
  - Written from cpu_dout[2*LAYERS-1:0] on prio_cs & ~cpu_rnw & cpu_cen.
  - Reset value: slot k = k.
- Selection: scan slots 0..LAYERS-1; the first slot naming an opaque, enabled layer wins.
  - A slot value ≥ LAYERS counts as transparent.
  - Duplicate slot values are legal.
  - If no slot wins, output the pixel of the layer named in the last slot, even if transparent (background colour). If that slot value is ≥ LAYERS, use layer LAYERS-1.
- Blanking: RGB is forced to 0 whenever LHBL_dly & LVBL_dly is 0.
- Palette contents are not cleared by reset.
- Reset (rstn=0 at a clk edge):
  - pipeline registers, red/green/blue, LHBL_dly, LVBL_dly and pal_dout go to 0;
  - priority register returns to identity.

## Timing
- Pipeline runs on pxl_cen edges only:
  - S1 registers pxl_in, gfx_en-masked opacity and blanking;
  - S2 resolves the winner and forms the palette index;
  - S3 reads the palette and registers RGB and the delayed blanking.
- Latency: RGB and LHBL_dly/LVBL_dly appear 3 pxl_cen after the pixel is presented. The blanking delay equals the RGB delay exactly.
- A priority write takes effect at the first S2 evaluation after the write clk, which can be mid-line.
- A CPU write and a video read to the same entry in the same clk return the old data to video. The new data is visible from the next read.
- CPU access never stalls; the palette RAM is true dual-port.
- rstn asserted mid-frame: outputs are 0 on the next clk. After release, valid RGB resumes 3 pxl_cen later.

## Configuration
- JTCONTRA_NMIX_RDBACK_EN defined: CPU palette readback works as described.
- Not defined: pal_dout is tied to 0, and the palette RAM CPU port is write-only, which saves one read mux and register. Video behaviour is identical in both cases.

## Structure
- Package jtcontra_nmix_pkg holds:
  - the LW/AW derivation function;
  - the colour field offsets within a 16-bit entry;
  - the identity priority reset constant;
  - the transparent-code mask (4'h0).
- One sub-module, jtcontra_nmix_pal, is the dual-port palette RAM:
  - byte-write CPU port with optional registered read;
  - synchronous 16-bit video read port.
- Winner resolution stays in the top as a combinational priority scan feeding S2.

## Test plan
- Reset, then write entry {layer 0, pix 0x05} = 0x7C1F and feed layer 0 = 0x05 with layer 1 = 0x00 → RGB = (31,0,31) after 3 pxl_cen.
- Both layers opaque at the identity order → layer 0 wins. Write prio = 0b0001 (slot0 = 1, slot1 = 0) → layer 1's colour appears from the next pixel.
- All layers transparent with background entry {layer 1, pix 0x10} = 0x03E0 → green = 31, red = 0, blue = 0.
- gfx_en = 2'b10 with both layers opaque → layer 1's colour is shown.
- LHBL low for one pixel → that RGB slot is 0, and LHBL_dly is low at the same cycle.
- Write then read back byte 0x013 with RDBACK_EN → pal_dout = written value one clk later. Without the macro → pal_dout = 0.
